// File: rtl/spi_eeprom_slave.sv
// 25xx-style serial EEPROM emulated as an SPI slave, oversampling SCK/CS/MOSI on bus2ip_clk.
// Supports READ, WRITE (page wrap), WREN, WRDI, RDSR, WRSR with block protect and a timed write cycle.
module spi_eeprom_slave #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PAGE_W = 4,
    parameter int unsigned TWC    = 64
) (
    input  logic bus2ip_clk,
    input  logic rst,
    input  logic cpol,
    input  logic cpha,
    input  logic spi_sck,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic wip,
    output logic wel
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned TW    = $clog2(TWC + 1);
    localparam logic [ADDR_W-1:0] PG_MASK = ADDR_W'((1 << PAGE_W) - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, RD_SR, WR_SR, IGNORE
    } state_t;

    logic [1:0]        r_sck_s, r_cs_s, r_mosi_s;
    logic              r_sck_d, r_cs_d;
    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_sh_in;
    logic [7:0]        r_sh_out;
    logic [7:0]        r_addr_hi;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_is_wr;
    logic              r_data_done;
    logic              r_pend_wren, r_pend_wrdi;
    logic [1:0]        r_bp;
    logic [TW-1:0]     r_timer;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_mem [DEPTH];

    logic              w_sck, w_cs, w_mosi, w_lead, w_trail, w_sample, w_shift;
    logic              w_active, w_byte_done, w_cmd_done, w_commit, w_set_wel, w_clr_wel, w_prot;
    logic [7:0]        w_byte, w_sr;
    logic [ADDR_W-1:0] w_addr, w_ptr_pg;

    always_ff @(posedge bus2ip_clk) begin
        if (rst) begin
            r_sck_s  <= {2{cpol}};
            r_cs_s   <= '1;
            r_mosi_s <= '0;
            r_sck_d  <= cpol;
            r_cs_d   <= 1'b1;
        end else begin
            r_sck_s  <= {r_sck_s[0], spi_sck};
            r_cs_s   <= {r_cs_s[0], spi_cs};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_sck_d  <= r_sck_s[1];
            r_cs_d   <= r_cs_s[1];
        end
    end

    assign w_sck    = r_sck_s[1];
    assign w_cs     = r_cs_s[1];
    assign w_mosi   = r_mosi_s[1];
    assign w_lead   = (w_sck != r_sck_d) && (r_sck_d == cpol);
    assign w_trail  = (w_sck != r_sck_d) && (w_sck == cpol);
    assign w_sample = cpha ? w_trail : w_lead;
    assign w_shift  = cpha ? w_lead : w_trail;
    assign w_active = (r_state != IDLE);

    assign w_byte      = {r_sh_in, w_mosi};
    assign w_byte_done = w_active && w_sample && (r_bit_cnt == 3'd7);
    assign w_cmd_done  = w_byte_done && (r_state == CMD);
    assign w_addr      = ADDR_W'({r_addr_hi, w_byte});
    assign w_ptr_pg    = (r_ptr & ~PG_MASK) | ((r_ptr + 1'b1) & PG_MASK);
    assign w_sr        = {4'b0000, r_bp, wel, wip};

    // A byte completing on the same cycle as CS rise still counts toward the commit
    assign w_commit  = ((r_state == WR_DATA) || (r_state == WR_SR)) && (r_data_done || w_byte_done);
    assign w_set_wel = r_pend_wren || (w_cmd_done && (w_byte == 8'h06) && !wip);
    assign w_clr_wel = r_pend_wrdi || (w_cmd_done && (w_byte == 8'h04) && !wip);

    always_comb begin
        w_prot = 1'b0;
        case (r_bp)
            2'b00:   w_prot = 1'b0;
            2'b01:   w_prot = &r_ptr[ADDR_W-1 -: 2];
            2'b10:   w_prot = r_ptr[ADDR_W-1];
            default: w_prot = 1'b1;
        endcase
    end

    always_ff @(posedge bus2ip_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_sh_in     <= '0;
            r_sh_out    <= '0;
            r_addr_hi   <= '0;
            r_ptr       <= '0;
            r_is_wr     <= 1'b0;
            r_data_done <= 1'b0;
            r_pend_wren <= 1'b0;
            r_pend_wrdi <= 1'b0;
            r_bp        <= '0;
            r_timer     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            spi_miso    <= 1'b0;
            wip         <= 1'b0;
            wel         <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (wip) begin
                r_timer <= r_timer - 1'b1;
                if (r_timer == TW'(1)) wip <= 1'b0;
            end

            if (w_active && w_sample) begin
                r_sh_in   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 3'd7) begin
                    case (r_state)
                        CMD: begin
                            r_state <= IGNORE;
                            case (w_byte)
                                8'h03: if (!wip) begin
                                    r_state <= ADDR_HI;
                                    r_is_wr <= 1'b0;
                                end
                                8'h02: if (wel && !wip) begin
                                    r_state <= ADDR_HI;
                                    r_is_wr <= 1'b1;
                                end
                                8'h06: r_pend_wren <= !wip;
                                8'h04: r_pend_wrdi <= !wip;
                                8'h05: begin
                                    r_state  <= RD_SR;
                                    r_sh_out <= w_sr;
                                    if (!cpha) spi_miso <= w_sr[7];
                                end
                                8'h01: if (wel && !wip) r_state <= WR_SR;
                                default: ;
                            endcase
                        end
                        ADDR_HI: begin
                            r_addr_hi <= w_byte;
                            r_state   <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            if (r_is_wr) begin
                                r_state <= WR_DATA;
                                r_ptr   <= w_addr;
                            end else begin
                                r_state  <= RD_DATA;
                                r_sh_out <= r_mem[w_addr];
                                r_ptr    <= w_addr + 1'b1;
                                if (!cpha) spi_miso <= r_mem[w_addr][7];
                            end
                        end
                        RD_DATA: begin
                            r_sh_out <= r_mem[r_ptr];
                            r_ptr    <= r_ptr + 1'b1;
                            if (!cpha) spi_miso <= r_mem[r_ptr][7];
                        end
                        RD_SR: begin
                            r_sh_out <= w_sr;
                            if (!cpha) spi_miso <= w_sr[7];
                        end
                        WR_DATA: begin
                            r_data_done <= 1'b1;
                            r_ptr       <= w_ptr_pg;
                            if (!w_prot) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                            end
                        end
                        WR_SR: begin
                            if (!r_data_done) r_bp <= w_byte[3:2];
                            r_data_done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            // Bits already sampled in this byte select the next bit to present
            if (w_active && w_shift && ((r_state == RD_DATA) || (r_state == RD_SR)))
                spi_miso <= r_sh_out[3'd7 - r_bit_cnt];

            if (w_cs) begin
                if (!r_cs_d) begin
                    if (w_commit) begin
                        wel     <= 1'b0;
                        wip     <= 1'b1;
                        r_timer <= TW'(TWC);
                    end else if (w_set_wel) begin
                        wel <= 1'b1;
                    end else if (w_clr_wel) begin
                        wel <= 1'b0;
                    end
                end
                r_state     <= IDLE;
                r_bit_cnt   <= '0;
                spi_miso    <= 1'b0;
                r_data_done <= 1'b0;
                r_pend_wren <= 1'b0;
                r_pend_wrdi <= 1'b0;
            end else if (r_cs_d) begin
                r_state     <= CMD;
                r_bit_cnt   <= '0;
                spi_miso    <= 1'b0;
                r_data_done <= 1'b0;
                r_pend_wren <= 1'b0;
                r_pend_wrdi <= 1'b0;
            end
        end
    end

    always_ff @(posedge bus2ip_clk) begin
        if (r_wr_en) r_mem[r_wr_addr] <= r_wr_data;
    end
endmodule
